// File: rtl/seg_p2s_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : seg_p2s_ctrl
// Brief   : Shifts a 64-bit seven-segment pattern MSB-first into external
//           daisy-chained shift registers, then pulses the latch strobe.
//           Optional feature macro: SEG_AUTO_REFRESH_EN (resend on change).
// Revision: 1.0 - initial release
// ============================================================================
module seg_p2s_ctrl #(
  parameter int HALF_PERIOD = 4,
  parameter int NBITS       = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [NBITS-1:0] par_data_i,
  output logic             s_clk_o,
  output logic             s_dat_o,
  output logic             s_lat_o,
  output logic             s_clrn_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int PW = $clog2(HALF_PERIOD) + 1;
  localparam int BW = (NBITS > 1) ? $clog2(NBITS) : 1;

  localparam logic [PW-1:0] PH_HIGH    = PW'(HALF_PERIOD);
  localparam logic [PW-1:0] PH_BIT_END = PW'(2 * HALF_PERIOD - 1);
  localparam logic [PW-1:0] PH_LAT_END = PW'(HALF_PERIOD - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(NBITS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_LATCH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q,  state_d;
  logic [NBITS-1:0] sreg_q,   sreg_d;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic [PW-1:0]    phase_q,  phase_d;
  logic             s_clrn_q;
  logic             s_clk_q, s_clk_d;
  logic             s_dat_q, s_dat_d;
  logic             s_lat_q, s_lat_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic             go_w;
  logic [NBITS-1:0] sreg_shift_w;

`ifdef SEG_AUTO_REFRESH_EN
  logic [NBITS-1:0] last_sent_q, last_sent_d;

  // Rotating brings sreg back to the captured pattern by LATCH time.
  assign sreg_shift_w = {sreg_q[NBITS-2:0], sreg_q[NBITS-1]};
  assign go_w         = start_i || (s_clrn_q && (par_data_i != last_sent_q));
`else
  assign sreg_shift_w = {sreg_q[NBITS-2:0], 1'b0};
  assign go_w         = start_i;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sreg_q   <= '0;
      bitcnt_q <= '0;
      phase_q  <= '0;
      s_clrn_q <= 1'b0;
      s_clk_q  <= 1'b0;
      s_dat_q  <= 1'b0;
      s_lat_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SEG_AUTO_REFRESH_EN
      last_sent_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      bitcnt_q <= bitcnt_d;
      phase_q  <= phase_d;
      s_clrn_q <= 1'b1;
      s_clk_q  <= s_clk_d;
      s_dat_q  <= s_dat_d;
      s_lat_q  <= s_lat_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SEG_AUTO_REFRESH_EN
      last_sent_q <= last_sent_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    bitcnt_d = bitcnt_q;
    phase_d  = phase_q;
`ifdef SEG_AUTO_REFRESH_EN
    last_sent_d = last_sent_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (go_w) begin
          state_d  = S_SHIFT;
          sreg_d   = par_data_i;
          bitcnt_d = BIT_LAST;
          phase_d  = '0;
        end
      end
      S_SHIFT: begin
        if (phase_q == PH_BIT_END) begin
          phase_d = '0;
          sreg_d  = sreg_shift_w;
          if (bitcnt_q == '0) begin
            state_d = S_LATCH;
          end else begin
            bitcnt_d = bitcnt_q - 1'b1;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_LATCH: begin
`ifdef SEG_AUTO_REFRESH_EN
        last_sent_d = sreg_q;
`endif
        if (phase_q == PH_LAT_END) begin
          state_d = S_DONE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from next state and registered, so the pins never glitch.
  always_comb begin
    s_clk_d = (state_d == S_SHIFT) && (phase_d >= PH_HIGH);
    s_dat_d = (state_d == S_SHIFT) && sreg_d[NBITS-1];
    s_lat_d = (state_d == S_LATCH);
    busy_d  = (state_d == S_SHIFT) || (state_d == S_LATCH);
    done_d  = (state_d == S_DONE);
  end

  assign s_clk_o  = s_clk_q;
  assign s_dat_o  = s_dat_q;
  assign s_lat_o  = s_lat_q;
  assign s_clrn_o = s_clrn_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule
`default_nettype wire
